// File: rtl/pc_sequencer.sv
// Program-counter sequencer: registered fetch address with stall, trap vectoring,
// branch redirect and a circular return-address stack for call/return.
module pc_sequencer #(
    parameter int unsigned      WIDTH     = 64,
    parameter int unsigned      STEP      = 1,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter logic [WIDTH-1:0] TRAP_VEC  = '0,
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             trap,
    input  logic             redirect,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic             pc_valid,
    output logic             ras_empty,
    output logic             ras_full,
    output logic [1:0]       ras_err
);

    localparam int unsigned      PtrW  = $clog2(RAS_DEPTH);
    localparam int unsigned      CntW  = PtrW + 1;
    localparam logic [WIDTH-1:0] StepW = WIDTH'(STEP);
    localparam logic [CntW-1:0]  CntMax = CntW'(RAS_DEPTH);

    typedef enum logic {StStart, StRun} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  pc_q, pc_d;
    logic [PtrW-1:0]   ptr_q, ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [1:0]        err_q, err_d;
    logic              push;
    logic [WIDTH-1:0]  ras_q [RAS_DEPTH];

    assign pc        = pc_q;
    assign pc_plus   = pc_q + StepW;
    assign pc_valid  = (state_q == StRun);
    assign ras_empty = (count_q == '0);
    assign ras_full  = (count_q == CntMax);
    assign ras_err   = err_q;

    always_comb begin
        state_d = StRun;
        pc_d    = pc_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        err_d   = err_q;
        push    = 1'b0;
        // The first cycle out of reset only raises pc_valid; controls are ignored.
        if (state_q == StRun) begin
            if (trap) begin
                pc_d = TRAP_VEC;
            end else if (stall) begin
                pc_d = pc_q;
            end else if (ret) begin
                if (count_q != '0) begin
                    pc_d    = ras_q[ptr_q];
                    ptr_d   = ptr_q - PtrW'(1);
                    count_d = count_q - CntW'(1);
                end else begin
                    pc_d     = target;
                    err_d[1] = 1'b1;
                end
                if (call) begin
                    err_d[1] = 1'b1;
                end
            end else if (call) begin
                push  = 1'b1;
                ptr_d = ptr_q + PtrW'(1);
                pc_d  = target;
                // When full the push lands on the oldest slot and the count saturates.
                if (count_q == CntMax) begin
                    err_d[0] = 1'b1;
                end else begin
                    count_d = count_q + CntW'(1);
                end
            end else if (redirect) begin
                pc_d = target;
            end else begin
                pc_d = pc_plus;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StStart;
            pc_q    <= RESET_PC;
            ptr_q   <= '0;
            count_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            ras_q[ptr_d] <= pc_plus;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed vectors push expected state, monitors
// pop and compare after each rising edge.
module tb_pc_sequencer;

    typedef struct packed {
        logic [63:0] pc;
        logic        valid;
        logic [3:0]  flags;  // {ras_empty, ras_full, ras_err[1], ras_err[0]}
    } exp_t;

    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] pc_plus;
    } exp8_t;

    logic        clk;
    logic        rst_n;
    logic        stall, trap, redirect, call, ret;
    logic [63:0] target;
    logic [63:0] pc, pc_plus;
    logic        pc_valid, ras_empty, ras_full;
    logic [1:0]  ras_err;

    logic        redirect8;
    logic [7:0]  target8;
    logic [7:0]  pc8, pc_plus8;
    logic        pc_valid8, ras_empty8, ras_full8;
    logic [1:0]  ras_err8;

    exp_t  exp_q  [$];
    exp8_t exp8_q [$];
    int    checks;
    int    errors;

    pc_sequencer #(
        .WIDTH     (64),
        .STEP      (1),
        .RESET_PC  (64'h100),
        .TRAP_VEC  (64'h8),
        .RAS_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .trap      (trap),
        .redirect  (redirect),
        .call      (call),
        .ret       (ret),
        .target    (target),
        .pc        (pc),
        .pc_plus   (pc_plus),
        .pc_valid  (pc_valid),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_err   (ras_err)
    );

    pc_sequencer #(
        .WIDTH     (8),
        .STEP      (4),
        .RESET_PC  (8'h0),
        .TRAP_VEC  (8'h0),
        .RAS_DEPTH (4)
    ) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (1'b0),
        .trap      (1'b0),
        .redirect  (redirect8),
        .call      (1'b0),
        .ret       (1'b0),
        .target    (target8),
        .pc        (pc8),
        .pc_plus   (pc_plus8),
        .pc_valid  (pc_valid8),
        .ras_empty (ras_empty8),
        .ras_full  (ras_full8),
        .ras_err   (ras_err8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Main monitor: every expectation corresponds to the state after one rising edge.
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pc", pc, e.pc);
            chk("pc_plus", pc_plus, e.pc + 64'd1);
            chk("pc_valid", {63'd0, pc_valid}, {63'd0, e.valid});
            chk("ras_flags", {60'd0, ras_empty, ras_full, ras_err}, {60'd0, e.flags});
        end
    end

    always @(posedge clk) begin
        #2;
        if (exp8_q.size() > 0) begin
            exp8_t e;
            e = exp8_q.pop_front();
            chk("pc8", {56'd0, pc8}, {56'd0, e.pc});
            chk("pc_plus8", {56'd0, pc_plus8}, {56'd0, e.pc_plus});
            chk("state8", {59'd0, pc_valid8, ras_empty8, ras_full8, ras_err8}, 64'b11000);
        end
    end

    task automatic cyc(input logic rn, input logic st, input logic tr, input logic rd,
                       input logic ca, input logic re, input logic [63:0] tgt,
                       input logic [63:0] epc, input logic ev, input logic [3:0] ef);
        @(negedge clk);
        rst_n    = rn;
        stall    = st;
        trap     = tr;
        redirect = rd;
        call     = ca;
        ret      = re;
        target   = tgt;
        exp_q.push_back('{pc: epc, valid: ev, flags: ef});
    endtask

    task automatic cyc8(input logic rd, input logic [7:0] tgt, input logic [7:0] epc,
                        input logic [7:0] eplus);
        @(negedge clk);
        redirect8 = rd;
        target8   = tgt;
        exp8_q.push_back('{pc: epc, pc_plus: eplus});
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        stall     = 1'b0;
        trap      = 1'b0;
        redirect  = 1'b0;
        call      = 1'b0;
        ret       = 1'b0;
        target    = '0;
        redirect8 = 1'b0;
        target8   = '0;

        //   rn st tr rd ca re  target     exp_pc     v  {empty,full,err1,err0}
        // Reset and start-up
        cyc(0, 0, 0, 0, 0, 0, 64'h0,   64'h100, 0, 4'b1000);
        cyc(0, 0, 0, 0, 0, 0, 64'h0,   64'h100, 0, 4'b1000);
        cyc(1, 0, 0, 0, 0, 0, 64'h0,   64'h100, 1, 4'b1000);
        cyc(1, 0, 0, 0, 0, 0, 64'h0,   64'h101, 1, 4'b1000);
        cyc(1, 0, 0, 0, 0, 0, 64'h0,   64'h102, 1, 4'b1000);
        cyc(1, 0, 0, 0, 0, 0, 64'h0,   64'h103, 1, 4'b1000);
        cyc(1, 0, 0, 0, 0, 0, 64'h0,   64'h104, 1, 4'b1000);
        cyc(1, 0, 0, 0, 0, 0, 64'h0,   64'h105, 1, 4'b1000);
        // Redirect blocked by stall, then taken
        cyc(1, 1, 0, 1, 0, 0, 64'h200, 64'h105, 1, 4'b1000);
        cyc(1, 0, 0, 1, 0, 0, 64'h200, 64'h200, 1, 4'b1000);
        cyc(1, 0, 0, 0, 0, 0, 64'h0,   64'h201, 1, 4'b1000);
        // Nested call/ret, ret immediately after call
        cyc(1, 0, 0, 1, 0, 0, 64'h10,  64'h10,  1, 4'b1000);
        cyc(1, 0, 0, 0, 1, 0, 64'h300, 64'h300, 1, 4'b0000);
        cyc(1, 0, 0, 0, 1, 0, 64'h400, 64'h400, 1, 4'b0000);
        cyc(1, 0, 0, 0, 0, 1, 64'h0,   64'h301, 1, 4'b0000);
        cyc(1, 0, 0, 0, 0, 1, 64'h0,   64'h11,  1, 4'b1000);
        // Five calls overflow a four-entry stack, then five rets underflow it
        cyc(1, 0, 0, 1, 0, 0, 64'h10,  64'h10,  1, 4'b1000);
        cyc(1, 0, 0, 0, 1, 0, 64'h20,  64'h20,  1, 4'b0000);
        cyc(1, 0, 0, 0, 1, 0, 64'h30,  64'h30,  1, 4'b0000);
        cyc(1, 0, 0, 0, 1, 0, 64'h40,  64'h40,  1, 4'b0000);
        cyc(1, 0, 0, 0, 1, 0, 64'h50,  64'h50,  1, 4'b0100);
        cyc(1, 0, 0, 0, 1, 0, 64'h60,  64'h60,  1, 4'b0101);
        cyc(1, 0, 0, 0, 0, 1, 64'h0,   64'h51,  1, 4'b0001);
        cyc(1, 0, 0, 0, 0, 1, 64'h0,   64'h41,  1, 4'b0001);
        cyc(1, 0, 0, 0, 0, 1, 64'h0,   64'h31,  1, 4'b0001);
        cyc(1, 0, 0, 0, 0, 1, 64'h0,   64'h21,  1, 4'b1001);
        cyc(1, 0, 0, 0, 0, 1, 64'h999, 64'h999, 1, 4'b1011);
        // Trap beats stall and call; the stacked entry survives
        cyc(1, 0, 0, 0, 1, 0, 64'h50,  64'h50,  1, 4'b0011);
        cyc(1, 1, 1, 0, 1, 0, 64'h123, 64'h8,   1, 4'b0011);
        cyc(1, 0, 0, 0, 0, 1, 64'h0,   64'h99a, 1, 4'b1011);
        // Mid-run reset wins over trap, clears sticky errors and the stack
        cyc(0, 0, 1, 0, 0, 0, 64'h0,   64'h100, 0, 4'b1000);
        cyc(1, 0, 0, 0, 0, 0, 64'h0,   64'h100, 1, 4'b1000);
        // call+ret together: ret wins, error flagged
        cyc(1, 0, 0, 0, 1, 0, 64'h40,  64'h40,  1, 4'b0000);
        cyc(1, 0, 0, 0, 1, 1, 64'h77,  64'h101, 1, 4'b1010);
        cyc(1, 0, 0, 0, 0, 0, 64'h0,   64'h102, 1, 4'b1010);
        cyc(1, 1, 0, 0, 0, 1, 64'h0,   64'h102, 1, 4'b1010);
        cyc(1, 0, 0, 0, 1, 0, 64'h10,  64'h10,  1, 4'b0010);
        cyc(1, 1, 0, 0, 0, 1, 64'h0,   64'h10,  1, 4'b0010);
        cyc(1, 0, 0, 0, 0, 1, 64'h0,   64'h103, 1, 4'b1010);
        @(negedge clk);
        stall = 1'b0;
        ret   = 1'b0;

        // 8-bit, step-4 instance: wrap at the top of the address space
        cyc8(1, 8'hFC, 8'hFC, 8'h00);
        cyc8(0, 8'h00, 8'h00, 8'h04);
        cyc8(0, 8'h00, 8'h04, 8'h08);
        cyc8(1, 8'hF8, 8'hF8, 8'hFC);
        cyc8(0, 8'h00, 8'hFC, 8'h00);
        cyc8(0, 8'h00, 8'h00, 8'h04);
        @(negedge clk);
        redirect8 = 1'b0;
        @(negedge clk);

        chk("queues_drained", 64'(exp_q.size() + exp8_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the single-cycle datapath. It generalises the fixed 64-bit PC to configurable width, step and reset vector. It adds stall, trap vectoring and a hardware return-address stack (RAS) for call/return. It sits between the branch unit and instruction memory, and presents the current fetch address and its sequential successor every cycle.

## Interface
- `WIDTH`, 64, PC width in bits.
- `STEP`, 1, sequential increment (word-addressed instruction memory).
- `RESET_PC`, 0, fetch address after reset.
- `TRAP_VEC`, 0, target loaded on `trap`.
- `RAS_DEPTH`, 4, return-stack entries (power of two, ≥2).

- `clk`  in  1  single clock, all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `stall`  in  1  hold PC and RAS.
- `trap`  in  1  vector to `TRAP_VEC`, overrides everything incl. stall.
- `redirect`  in  1  taken branch/jump to `target`.
- `call`  in  1  push `pc_plus`, jump to `target`.
- `ret`  in  1  pop RAS, jump to popped address.
- `target`  in  WIDTH  branch/call destination; also fallback for `ret` on empty RAS.
- `pc`  out  WIDTH  current fetch address (registered).
- `pc_plus`  out  WIDTH  `pc + STEP` mod 2^WIDTH (combinational from `pc`).
- `pc_valid`  out  1  fetch address valid.
- `ras_empty`  out  1  RAS holds 0 entries.
- `ras_full`  out  1  RAS holds `RAS_DEPTH` entries.
- `ras_err`  out  2  sticky: bit0 overflow (push when full), bit1 underflow (pop when empty) or call+ret same cycle.

## Operation
- Reset (`rst_n`=0 at edge): `pc`=RESET_PC, `pc_valid`=0, RAS count=0, `ras_err`=0, `ras_empty`=1, `ras_full`=0.
- First edge with `rst_n`=1: `pc` stays RESET_PC, `pc_valid`→1. No control input is acted on in this cycle.
- Afterwards, per edge, with first match winning:
  1. `trap`: `pc`←TRAP_VEC. RAS untouched. Ignores `stall`.
  2. `stall`: `pc` and RAS hold. `call`/`ret`/`redirect` are dropped, not queued.
  3. `ret`: if RAS non-empty, `pc`←top and count−1. If empty, `pc`←`target` and set `ras_err[1]`. If `call` is also 1, `call` is ignored and `ras_err[1]` is set.
  4. `call`: push `pc_plus`, `pc`←`target`. If full, overwrite oldest entry (circular), count stays RAS_DEPTH, set `ras_err[0]`.
  5. `redirect`: `pc`←`target`.
  6. Otherwise `pc`←`pc_plus`.
- RAS is a circular buffer with a top pointer and a saturating count of log2(RAS_DEPTH)+1 bits. Pop reads the entry at the top pointer, then decrements it.
- Arithmetic is unsigned, modulo 2^WIDTH. `pc`=2^WIDTH−STEP increments to 0 with no flag.
- `ras_err` bits are sticky until reset.

## Timing
- Control inputs are sampled at the rising edge. `pc` reflects the decision one cycle later. Latency from `redirect`/`call`/`ret`/`trap` to the new `pc` is 1 cycle.
- `pc_plus` tracks `pc` in the same cycle, with no extra register.
- `ras_empty`/`ras_full` are registered with the count and valid in the same cycle as the resulting `pc`.
- Call then ret on consecutive cycles: the ret pops the address pushed one cycle earlier. No bypass stall is required.
- Reset mid-operation: takes effect at the next edge regardless of `stall`/`trap`. RAS contents are discarded (count=0).
- `pc_valid` falls in the cycle after the `rst_n`=0 edge and rises one edge after reset release.

## Test plan
- Reset/start (WIDTH=64, RESET_PC=0x100): hold `rst_n`=0 for 2 cycles, release, idle. Expect `pc`=0x100 with `pc_valid`=0, then 0x100 with `pc_valid`=1, then 0x101, then 0x102.
- Redirect and stall: at `pc`=0x105 assert `redirect`, `target`=0x200, together with `stall`. Expect `pc` holds 0x105. Drop `stall`, keep `redirect`. Expect 0x200, then 0x201.
- Call/ret nesting (RAS_DEPTH=4): call to 0x300 from 0x10, then call to 0x400 from 0x300. Expect two rets return to 0x301, then 0x11. Expect `ras_empty`=1 after the second ret, with `ras_err`=0.
- Overflow/underflow: issue 5 calls from PCs 0x10, 0x20, 0x30, 0x40, 0x50. Expect `ras_full`=1 and `ras_err[0]`=1. Expect 4 rets return to 0x51, 0x41, 0x31, 0x21. A 5th ret with `target`=0x999 goes to 0x999 and sets `ras_err[1]`=1.
- Trap priority: assert `trap`+`stall`+`call` at `pc`=0x50 (TRAP_VEC=0x8). Expect `pc`=0x8 next cycle and RAS count unchanged.
- Wrap (WIDTH=8, STEP=4): redirect to 0xFC. Expect `pc_plus`=0x00 and next `pc`=0x00.
